// File: rtl/fir_param_pipelined.sv
// Purpose : parameterised pipelined FIR filter with serially loaded coefficients.
// Latency : L = 1 + ceil(log2(TAPS)) enabled cycles from accepted sample to out_valid.
// Backpr. : none; en=0 freezes the whole data path, coefficient writes still proceed.
//
// Ports:
//   clk        - single clock, all state on its rising edge
//   reset      - synchronous active-high reset, priority over everything else
//   en         - global data-path clock enable
//   in_valid   - data_in carries a sample this cycle
//   data_in    - signed DW-bit sample
//   coef_wr    - write coef_data to the tap addressed by the internal write pointer
//   coef_data  - signed CW-bit coefficient, Q1.(CW-1)
//   coef_done  - one-cycle pulse after the write to tap TAPS-1
//   out_valid  - data_out holds a new filtered sample
//   data_out   - signed OW-bit filtered sample
//
// Build option: define FIR_SATURATE_EN to clamp data_out when OW is narrower than
// the adder-tree result; otherwise the low OW bits are kept (two's-complement wrap).
module fir_param_pipelined #(
  parameter int TAPS = 16,
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int OW   = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] data_in,
  input  logic                 coef_wr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_done,
  output logic                 out_valid,
  output logic signed [OW-1:0] data_out
);

  localparam int STAGES = $clog2(TAPS);
  localparam int LAT    = 1 + STAGES;
  localparam int PW     = $clog2(TAPS);
  localparam int PDW    = DW + CW;
  // Tree result width: DW+1 bits after scaling, plus one bit per adder stage.
  localparam int TW     = DW + 1 + STAGES;
  localparam logic [PW-1:0] LAST_TAP = PW'(TAPS - 1);

  // Number of operands present at a given tree level (level 0 = scaled products).
  function automatic int node_cnt(input int lvl);
    int n;
    n = TAPS;
    for (int j = 0; j < lvl; j++) n = (n + 1) / 2;
    return n;
  endfunction

  logic signed [CW-1:0]  r_coef  [0:TAPS-1];
  logic [PW-1:0]         r_wr_ptr;
  logic                  r_coef_done;
  logic signed [DW-1:0]  r_dly   [1:TAPS-1];
  logic signed [DW-1:0]  w_tap   [0:TAPS-1];
  logic signed [PDW-1:0] r_prod  [0:TAPS-1];
  logic signed [TW-1:0]  w_lvl   [0:STAGES][0:TAPS-1];
  logic signed [TW-1:0]  r_lvl   [1:STAGES][0:TAPS-1];
  logic [LAT-1:0]        r_vld;
  logic signed [TW-1:0]  w_sum;
  logic signed [OW-1:0]  w_out;

  // Coefficient loader: independent of en so coefficients can be loaded while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
      r_wr_ptr    <= '0;
      r_coef_done <= 1'b0;
    end else begin
      r_coef_done <= coef_wr && (r_wr_ptr == LAST_TAP);
      if (coef_wr) begin
        r_coef[r_wr_ptr] <= coef_data;
        r_wr_ptr         <= (r_wr_ptr == LAST_TAP) ? '0 : r_wr_ptr + PW'(1);
      end
    end
  end

  // Tap 0 is the live input; taps 1..TAPS-1 are previously accepted samples.
  always_comb begin
    w_tap[0] = data_in;
    for (int k = 1; k < TAPS; k++) w_tap[k] = r_dly[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k < TAPS; k++) r_dly[k] <= '0;
    end else if (en && in_valid) begin
      r_dly[1] <= data_in;
      for (int k = 2; k < TAPS; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // Full-precision products; coefficient writes in the same cycle are not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) r_prod[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < TAPS; k++) r_prod[k] <= PDW'(w_tap[k]) * PDW'(r_coef[k]);
    end
  end

  // Level 0 takes bits [PDW-1:CW-1] of each product: an arithmetic shift by CW-1
  // (floor rounding) kept to DW+1 bits, then sign-extended to the tree width.
  // Higher levels mirror the tree registers so one indexing scheme serves all levels.
  always_comb begin
    for (int s = 0; s <= STAGES; s++)
      for (int i = 0; i < TAPS; i++) w_lvl[s][i] = '0;
    for (int i = 0; i < TAPS; i++) w_lvl[0][i] = TW'($signed(r_prod[i][PDW-1:CW-1]));
    for (int s = 1; s <= STAGES; s++)
      for (int i = 0; i < TAPS; i++) w_lvl[s][i] = r_lvl[s][i];
  end

  // Registered binary adder tree. Every level is held at the final width; values
  // never exceed the DW+1+level bits that a pairwise sum at that level can need.
  // An odd leftover operand is registered unchanged into the next level.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 1; s <= STAGES; s++)
        for (int i = 0; i < TAPS; i++) r_lvl[s][i] <= '0;
    end else if (en) begin
      for (int s = 1; s <= STAGES; s++) begin
        for (int i = 0; i < TAPS; i++) begin
          if (2*i + 1 < node_cnt(s - 1))
            r_lvl[s][i] <= w_lvl[s-1][2*i] + w_lvl[s-1][2*i+1];
          else if (2*i < node_cnt(s - 1))
            r_lvl[s][i] <= w_lvl[s-1][2*i];
          else
            r_lvl[s][i] <= '0;
        end
      end
    end
  end

  // Valid travels alongside the data: one bit per pipeline register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (en) begin
      r_vld <= {r_vld[LAT-2:0], in_valid};
    end
  end

  assign w_sum = r_lvl[STAGES][0];

  generate
    if (OW >= TW) begin : g_sext
      assign w_out = OW'(w_sum);
    end else begin : g_narrow
`ifdef FIR_SATURATE_EN
      localparam logic signed [TW-1:0] SAT_MAX = {{(TW-OW+1){1'b0}}, {(OW-1){1'b1}}};
      localparam logic signed [TW-1:0] SAT_MIN = {{(TW-OW+1){1'b1}}, {(OW-1){1'b0}}};
      always_comb begin
        if (w_sum > SAT_MAX)      w_out = SAT_MAX[OW-1:0];
        else if (w_sum < SAT_MIN) w_out = SAT_MIN[OW-1:0];
        else                      w_out = w_sum[OW-1:0];
      end
`else
      assign w_out = w_sum[OW-1:0];
`endif
    end
  endgenerate

  assign data_out  = w_out;
  assign out_valid = r_vld[LAT-1];
  assign coef_done = r_coef_done;

endmodule

// File: doc/fir_param_pipelined.md
FIR_PARAM_PIPELINED -- requirements
Module: fir_param_pipelined

Interface
REQ-001 SHALL have parameter TAPS, default 16, number of filter taps (2..256, any integer, not only powers of two).
REQ-002 SHALL have parameter DW, default 16, signed input sample width.
REQ-003 SHALL have parameter CW, default 16, signed coefficient width (Q1.(CW-1)).
REQ-004 SHALL have parameter OW, default 24, signed output width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  global clock enable; low freezes the whole data path.
REQ-008 SHALL have port in_valid  input  1  data_in carries a new sample this cycle.
REQ-009 SHALL have port data_in  input  DW  signed sample.
REQ-010 SHALL have port coef_wr  input  1  write coef_data to the tap at the internal write pointer.
REQ-011 SHALL have port coef_data  input  CW  signed coefficient.
REQ-012 SHALL have port coef_done  output  1  one-cycle pulse after the write to tap TAPS-1.
REQ-013 SHALL have port out_valid  output  1  data_out holds a new filtered sample.
REQ-014 SHALL have port data_out  output  OW  signed filtered sample.

Function
REQ-015 Delay line SHALL shift by one tap only on cycles with en=1 and in_valid=1; tap 0 is data_in combinationally.
REQ-016 Each tap product SHALL be a full DW+CW signed product, registered, then arithmetically shifted right by CW-1 (truncation toward minus infinity) to DW+1 bits.
REQ-017 Products SHALL be summed by a registered binary adder tree of ceil(log2(TAPS)) stages; each stage widens by 1 bit; an odd leftover operand is passed through registered to the next stage.
REQ-018 Latency SHALL be L = 1 + ceil(log2(TAPS)) enabled cycles from accepted sample to out_valid; out_valid is in_valid delayed by L enabled cycles.
REQ-019 With en=0 all pipeline registers, out_valid and data_out SHALL hold their values.
REQ-020 Final conversion: if OW >= tree width, data_out SHALL be sign-extended; otherwise handled per REQ-029/REQ-030.
REQ-021 coef_wr SHALL be honoured regardless of en; the write pointer increments and wraps from TAPS-1 to 0.
REQ-022 coef_done SHALL pulse high on the cycle after the write to tap TAPS-1, low otherwise.
REQ-023 A coefficient written in cycle N SHALL affect products registered in cycle N+1 onward; a product registered in cycle N uses the old value.
REQ-024 Simultaneous coef_wr and in_valid SHALL both be serviced in the same cycle.

Reset
REQ-025 reset SHALL take priority over en, in_valid and coef_wr.
REQ-026 On reset, delay line, product and tree registers, coefficients, write pointer SHALL clear to 0; data_out=0, out_valid=0, coef_done=0 the next cycle.
REQ-027 Reset mid-stream SHALL discard all in-flight samples; no out_valid until L enabled cycles after the first accepted post-reset sample.

Configuration
REQ-028 Macro FIR_SATURATE_EN SHALL select the narrowing mode when OW < tree width.
REQ-029 With FIR_SATURATE_EN defined, data_out SHALL clamp to [-2^(OW-1), 2^(OW-1)-1].
REQ-030 Without FIR_SATURATE_EN, data_out SHALL be the OW least significant bits of the sum (two's-complement wrap).

Verification
REQ-031 TAPS=4, coefs 0x4000,0x2000,0x1000,0x0800, impulse 0x7FFF then zeros -> out_valid after 3 cycles, data_out 0x3FFF,0x1FFF,0x0FFF,0x07FF then 0.
REQ-032 TAPS=4, OW=16, coefs all 0x7FFF, constant input 0x7FFF -> steady state 0x7FFF with FIR_SATURATE_EN, 0xFFF8 without.
REQ-033 Same as REQ-031 with en low for 2 cycles mid-stream -> identical output sequence, stretched by 2 cycles, outputs held while en=0.
REQ-034 Write 4 coefs (TAPS=4) -> coef_done high exactly one cycle after 4th write; 5th write lands on tap 0.
REQ-035 Reset asserted with 2 samples in flight -> out_valid=0 and data_out=0 next cycle; no stale outputs afterwards.
REQ-036 TAPS=5, all coefs 0x4000, constant input 0x0100 -> latency 4, steady-state data_out 0x0280.
